// File: rtl/simple_mac_rx.sv
// -----------------------------------------------------------------------------
// simple_mac_rx
//
// MII receive MAC. Hunts for preamble/SFD and packs nibbles into bytes (low
// nibble first). It checks frame length, MII receive errors, nibble alignment
// and, optionally, the FCS. It emits a byte stream framed by sop/eop/err in
// the PHY rx clock domain.
//
// A short delay line holds back the newest bytes. The byte that turns out to
// be last can then carry eop, and the FCS bytes can be dropped when CRC
// checking is enabled.
//
// Build option:
//   SIMPLE_MAC_RX_CRC_EN  defined     -> CRC-32 check, delay line depth 5,
//                                        FCS stripped from the output.
//                         not defined -> no CRC logic, depth 1,
//                                        FCS delivered as payload.
//
// Parameters:
//   MIN_LEN  minimum frame bytes after SFD incl. FCS (shorter = runt)
//   MAX_LEN  maximum frame bytes after SFD incl. FCS (longer = truncated)
//   STAT_W   width of the saturating good/bad frame counters
//
// Ports:
//   eth_rxclk  in   MII rx clock; every flop uses its rising edge
//   rstn       in   asynchronous active-low reset (released synchronously)
//   eth_rxdv   in   MII receive data valid
//   eth_rxer   in   MII receive error
//   eth_rxd    in   MII receive nibble
//   rx_data    out  received byte
//   rx_valid   out  one-cycle strobe for rx_data; there is no backpressure
//   rx_sop     out  with rx_valid: first byte of the frame
//   rx_eop     out  with rx_valid: last byte of the frame
//   rx_err     out  with rx_eop: the frame is bad
//   stat_good  out  count of frames that ended without error (saturating)
//   stat_bad   out  count of frames that ended with error (saturating)
// -----------------------------------------------------------------------------
module simple_mac_rx #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int STAT_W  = 16
) (
   input  logic              eth_rxclk,
   input  logic              rstn,
   input  logic              eth_rxdv,
   input  logic              eth_rxer,
   input  logic [3:0]        eth_rxd,
   output logic [7:0]        rx_data,
   output logic              rx_valid,
   output logic              rx_sop,
   output logic              rx_eop,
   output logic              rx_err,
   output logic [STAT_W-1:0] stat_good,
   output logic [STAT_W-1:0] stat_bad
);

`ifdef SIMPLE_MAC_RX_CRC_EN
   localparam int DEPTH = 5;
`else
   localparam int DEPTH = 1;
`endif
   localparam int                CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [15:0]       MIN_C   = 16'(MIN_LEN);
   localparam logic [15:0]       MAX_C   = 16'(MAX_LEN);

   localparam logic [3:0] NIB_PRE = 4'h5;
   localparam logic [3:0] NIB_SFD = 4'hD;

`ifdef SIMPLE_MAC_RX_CRC_EN
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   // Running over data plus its own FCS leaves this constant remainder
   // when the frame is intact.
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Reset synchroniser: assertion is immediate, release waits two clock edges.
   // ---------------------------------------------------------------------------
   logic [1:0] rst_sync;
   logic       rst_n_int;

   always_ff @(posedge eth_rxclk or negedge rstn) begin
      if (!rstn) rst_sync <= 2'b00;
      else       rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n_int = rst_sync[1];

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t            state;
   logic              phase;       // 0: expect low nibble, 1: expect high nibble
   logic [3:0]        low_nib;
   logic [CNT_W-1:0]  line_cnt;    // occupied delay-line entries
   logic [15:0]       byte_cnt;    // bytes after SFD, saturating
   logic              rxer_seen;
   logic              emitted;     // a byte of this frame has already gone out
   logic [7:0]        line [DEPTH];
`ifdef SIMPLE_MAC_RX_CRC_EN
   logic [31:0]       crc;
`endif

   // ---------------------------------------------------------------------------
   // Per-cycle decode
   // ---------------------------------------------------------------------------
   logic       byte_stb;
   logic [7:0] new_byte;
   logic       frame_end;
   logic       line_full;
   logic       over_len;
   logic       fcs_bad;
   logic       frame_bad;
   logic [7:0] oldest;

   assign byte_stb  = (state == DATA) && eth_rxdv && phase;
   assign new_byte  = {eth_rxd, low_nib};
   assign frame_end = (state == DATA) && !eth_rxdv;
   assign line_full = (line_cnt == DEPTH_C);
   // The byte completing now would be number MAX_LEN+1.
   assign over_len  = byte_stb && (byte_cnt == MAX_C);
   assign oldest    = line[DEPTH-1];

`ifdef SIMPLE_MAC_RX_CRC_EN
   assign fcs_bad = (crc != CRC_RESIDUE);
`else
   assign fcs_bad = 1'b0;
`endif

   // phase still high at end of frame means an odd nibble count.
   assign frame_bad = rxer_seen | phase | (byte_cnt < MIN_C) | fcs_bad;

`ifdef SIMPLE_MAC_RX_CRC_EN
   function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                            input logic [7:0]  b);
      logic [31:0] r;
      // NOTE: blocking assignments are correct here; r is a combinational
      // temporary that each loop iteration builds on, not a stored register.
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction
`endif

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Delay line: shifts on every assembled byte, oldest entry at DEPTH-1.
   // NOTE: the byte storage has no reset. line_cnt alone says which entries
   // are meaningful, so clearing it empties the line.
   // ---------------------------------------------------------------------------
   always_ff @(posedge eth_rxclk) begin
      if (byte_stb) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            line[i] <= line[i-1];
         end
         line[0] <= new_byte;
      end
   end

   // ---------------------------------------------------------------------------
   // Receive FSM, framing outputs and statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge eth_rxclk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state     <= IDLE;
         phase     <= 1'b0;
         low_nib   <= 4'h0;
         line_cnt  <= '0;
         byte_cnt  <= 16'h0;
         rxer_seen <= 1'b0;
         emitted   <= 1'b0;
`ifdef SIMPLE_MAC_RX_CRC_EN
         crc       <= 32'hFFFFFFFF;
`endif
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         rx_sop    <= 1'b0;
         rx_eop    <= 1'b0;
         rx_err    <= 1'b0;
         stat_good <= '0;
         stat_bad  <= '0;
      end else begin
         // Framing outputs are single-cycle pulses.
         rx_valid <= 1'b0;
         rx_sop   <= 1'b0;
         rx_eop   <= 1'b0;
         rx_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (eth_rxdv) state <= (eth_rxd == NIB_PRE) ? PRE : DROP;
            end

            PRE: begin
               if (!eth_rxdv) begin
                  state <= IDLE;
               end else if (eth_rxd == NIB_SFD) begin
                  state     <= DATA;
                  phase     <= 1'b0;
                  line_cnt  <= '0;
                  byte_cnt  <= 16'h0;
                  rxer_seen <= 1'b0;
                  emitted   <= 1'b0;
`ifdef SIMPLE_MAC_RX_CRC_EN
                  crc       <= 32'hFFFFFFFF;
`endif
               end else if (eth_rxd != NIB_PRE) begin
                  state <= DROP;
               end
            end

            DATA: begin
               if (frame_end) begin
                  // The oldest entry is the last byte delivered; with CRC
                  // the newer entries are the FCS and are simply dropped.
                  if (line_full) begin
                     rx_data  <= oldest;
                     rx_valid <= 1'b1;
                     rx_sop   <= !emitted;
                     rx_eop   <= 1'b1;
                     rx_err   <= frame_bad;
                     if (frame_bad) stat_bad  <= sat_inc(stat_bad);
                     else           stat_good <= sat_inc(stat_good);
                  end else begin
                     // Too short to deliver anything: count it, stay silent.
                     stat_bad <= sat_inc(stat_bad);
                  end
                  state    <= IDLE;
                  phase    <= 1'b0;
                  line_cnt <= '0;
                  emitted  <= 1'b0;
`ifdef SIMPLE_MAC_RX_CRC_EN
                  crc      <= 32'hFFFFFFFF;
`endif
               end else begin
                  if (eth_rxer) rxer_seen <= 1'b1;

                  if (!phase) begin
                     low_nib <= eth_rxd;
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (over_len) begin
                        // Truncate: close the frame on the oldest held byte
                        // and ignore everything until rxdv drops.
                        rx_data  <= oldest;
                        rx_valid <= 1'b1;
                        rx_sop   <= !emitted;
                        rx_eop   <= 1'b1;
                        rx_err   <= 1'b1;
                        stat_bad <= sat_inc(stat_bad);
                        state    <= DROP;
                        line_cnt <= '0;
                        emitted  <= 1'b0;
`ifdef SIMPLE_MAC_RX_CRC_EN
                        crc      <= 32'hFFFFFFFF;
`endif
                     end else begin
                        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'h1;
`ifdef SIMPLE_MAC_RX_CRC_EN
                        crc <= crc_byte(crc, new_byte);
`endif
                        if (line_full) begin
                           rx_data  <= oldest;
                           rx_valid <= 1'b1;
                           rx_sop   <= !emitted;
                           emitted  <= 1'b1;
                        end else begin
                           line_cnt <= line_cnt + 1'b1;
                        end
                     end
                  end
               end
            end

            DROP: begin
               if (!eth_rxdv) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_mac_rx.sv
// -----------------------------------------------------------------------------
// tb_simple_mac_rx
//
// Directed bench for simple_mac_rx. A table of frame recipes carries the
// expected delivered byte count, the eop error flag and the statistics
// effect. Each recipe is built, driven over MII and compared against a
// passive monitor. Hand-written sequences cover reset mid-frame and
// counter saturation. STAT_W is reduced so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_simple_mac_rx;

   localparam int STAT_W = 4;
`ifdef SIMPLE_MAC_RX_CRC_EN
   localparam bit CRC = 1'b1;
`else
   localparam bit CRC = 1'b0;
`endif

   logic              eth_rxclk = 1'b0;
   logic              rstn      = 1'b1;
   logic              eth_rxdv  = 1'b0;
   logic              eth_rxer  = 1'b0;
   logic [3:0]        eth_rxd   = 4'h0;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_sop;
   logic              rx_eop;
   logic              rx_err;
   logic [STAT_W-1:0] stat_good;
   logic [STAT_W-1:0] stat_bad;

   simple_mac_rx #(
      .MIN_LEN (64),
      .MAX_LEN (1518),
      .STAT_W  (STAT_W)
   ) dut (
      .eth_rxclk (eth_rxclk),
      .rstn      (rstn),
      .eth_rxdv  (eth_rxdv),
      .eth_rxer  (eth_rxer),
      .eth_rxd   (eth_rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_sop    (rx_sop),
      .rx_eop    (rx_eop),
      .rx_err    (rx_err),
      .stat_good (stat_good),
      .stat_bad  (stat_bad)
   );

   always #5 eth_rxclk = ~eth_rxclk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Output monitor (samples on the falling edge)
   // ---------------------------------------------------------------------------
   int         mon_valid = 0;
   int         mon_sop   = 0;
   int         mon_eop   = 0;
   int         mon_err   = 0;
   int         sop_wrong = 0;
   int         stray     = 0;
   bit         in_frame  = 1'b0;
   logic [7:0] mon_q [$];

   always @(negedge eth_rxclk) begin
      if (!rstn) begin
         in_frame = 1'b0;
      end else if (rx_valid) begin
         mon_valid++;
         mon_q.push_back(rx_data);
         if (rx_sop) mon_sop++;
         // sop belongs on exactly the first delivered byte of each frame.
         if (rx_sop == in_frame) sop_wrong++;
         if (rx_eop) begin
            mon_eop++;
            if (rx_err) mon_err++;
            in_frame = 1'b0;
         end else begin
            in_frame = 1'b1;
         end
      end else if (rx_sop || rx_eop || rx_err) begin
         stray++;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame construction and MII driving
   // ---------------------------------------------------------------------------
   logic [7:0] frame [$];

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic build(input int pay_len, input bit add_fcs, input int flip);
      logic [31:0] c;
      logic [31:0] fcs;
      frame.delete();
      for (int i = 0; i < pay_len; i++) frame.push_back(8'(i));
      if (add_fcs) begin
         c = 32'hFFFFFFFF;
         foreach (frame[i]) c = crc_upd(c, frame[i]);
         fcs = ~c;
         frame.push_back(fcs[7:0]);
         frame.push_back(fcs[15:8]);
         frame.push_back(fcs[23:16]);
         frame.push_back(fcs[31:24]);
      end
      if (flip >= 0) frame[flip] = frame[flip] ^ 8'h01;
   endtask

   task automatic drive_nib(input logic dv, input logic er, input logic [3:0] d);
      @(negedge eth_rxclk);
      eth_rxdv = dv;
      eth_rxer = er;
      eth_rxd  = d;
   endtask

   task automatic send_preamble(input bit rxer_pre);
      for (int i = 0; i < 15; i++) drive_nib(1'b1, rxer_pre && (i == 3), 4'h5);
      drive_nib(1'b1, 1'b0, 4'hD);
   endtask

   task automatic send_frame(input bit bad_pre, input bit rxer_pre,
                             input int rxer_byte, input bit odd, input int gap);
      if (bad_pre) begin
         drive_nib(1'b1, 1'b0, 4'h5);
         drive_nib(1'b1, 1'b0, 4'h5);
         drive_nib(1'b1, 1'b0, 4'hA);
      end else begin
         send_preamble(rxer_pre);
      end
      foreach (frame[i]) begin
         drive_nib(1'b1, i == rxer_byte, frame[i][3:0]);
         drive_nib(1'b1, 1'b0, frame[i][7:4]);
      end
      if (odd) drive_nib(1'b1, 1'b0, 4'h3);
      drive_nib(1'b0, 1'b0, 4'h0);
      repeat (gap) @(negedge eth_rxclk);
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      string name;
      int    pay_len;
      bit    add_fcs;
      int    flip_byte;
      int    rxer_byte;
      bit    rxer_pre;
      bit    odd;
      bit    bad_pre;
      int    exp_valid;
      bit    exp_err;
      int    exp_stat;   // 0: no change, 1: good++, 2: bad++
   } vec_t;

   vec_t vq [$];

   task automatic add(input string n, input int pay, input bit fcs, input int flip,
                      input int rxb, input bit rxp, input bit odd, input bit bp,
                      input int ev, input bit ee, input int es);
      vec_t v;
      v = '{n, pay, fcs, flip, rxb, rxp, odd, bp, ev, ee, es};
      vq.push_back(v);
   endtask

   function automatic int sat(input int v);
      return (v >= 15) ? 15 : v + 1;
   endfunction

   int exp_good = 0;
   int exp_bad  = 0;

   initial begin
      int pv, ps, pe, pr, qb, mism, e_eop0;

      //   name          pay  fcs flip rxer rxp odd bp  exp_valid             err  stat
      add("good",         60, 1,  -1,  -1, 0,  0,  0, CRC ? 60   : 64,   0,   1);
      add("fcs_flip",     60, 1,  10,  -1, 0,  0,  0, CRC ? 60   : 64,   CRC, CRC ? 2 : 1);
      add("rxer_data",    60, 1,  -1,  20, 0,  0,  0, CRC ? 60   : 64,   1,   2);
      add("rxer_pre",     60, 1,  -1,  -1, 1,  0,  0, CRC ? 60   : 64,   0,   1);
      add("runt",         20, 1,  -1,  -1, 0,  0,  0, CRC ? 20   : 24,   1,   2);
      add("len63",        59, 1,  -1,  -1, 0,  0,  0, CRC ? 59   : 63,   1,   2);
      add("three",         3, 0,  -1,  -1, 0,  0,  0, CRC ? 0    : 3,    1,   2);
      add("five",          5, 0,  -1,  -1, 0,  0,  0, CRC ? 1    : 5,    1,   2);
      add("zero",          0, 0,  -1,  -1, 0,  0,  0, 0,                 1,   2);
      add("odd_nibble",   60, 1,  -1,  -1, 0,  1,  0, CRC ? 60   : 64,   1,   2);
      add("long",       1600, 0,  -1,  -1, 0,  0,  0, CRC ? 1514 : 1518, 1,   2);
      add("after_long",   60, 1,  -1,  -1, 0,  0,  0, CRC ? 60   : 64,   0,   1);
      add("max_len",    1514, 1,  -1,  -1, 0,  0,  0, CRC ? 1514 : 1518, 0,   1);
      add("bad_pre",      60, 1,  -1,  -1, 0,  0,  1, 0,                 0,   0);

      // Reset state
      #1 rstn = 1'b0;
      repeat (3) @(negedge eth_rxclk);
      check("reset rx_valid",  rx_valid,  0);
      check("reset rx_data",   rx_data,   0);
      check("reset framing",   {rx_sop, rx_eop, rx_err}, 0);
      check("reset stat_good", stat_good, 0);
      check("reset stat_bad",  stat_bad,  0);
      rstn = 1'b1;
      repeat (5) @(negedge eth_rxclk);

      foreach (vq[k]) begin
         build(vq[k].pay_len, vq[k].add_fcs, vq[k].flip_byte);
         pv = mon_valid; ps = mon_sop; pe = mon_eop; pr = mon_err; qb = mon_q.size();
         send_frame(vq[k].bad_pre, vq[k].rxer_pre, vq[k].rxer_byte, vq[k].odd, 12);

         check({vq[k].name, " valid count"}, mon_valid - pv, vq[k].exp_valid);
         check({vq[k].name, " eop count"},   mon_eop - pe, (vq[k].exp_valid > 0) ? 1 : 0);
         check({vq[k].name, " sop count"},   mon_sop - ps, (vq[k].exp_valid > 0) ? 1 : 0);
         if (vq[k].exp_valid > 0)
            check({vq[k].name, " eop err"}, mon_err - pr, int'(vq[k].exp_err));
         mism = 0;
         for (int i = 0; i < vq[k].exp_valid; i++) begin
            if (qb + i >= mon_q.size()) mism++;
            else if (mon_q[qb + i] != frame[i]) mism++;
         end
         check({vq[k].name, " data mismatches"}, mism, 0);

         if (vq[k].exp_stat == 1) exp_good = sat(exp_good);
         if (vq[k].exp_stat == 2) exp_bad  = sat(exp_bad);
         check({vq[k].name, " stat_good"}, stat_good, exp_good);
         check({vq[k].name, " stat_bad"},  stat_bad,  exp_bad);
      end

      check("sop placement errors", sop_wrong, 0);
      check("eop/sop/err without valid", stray, 0);

      // Reset in the middle of a payload
      build(60, 1'b1, -1);
      e_eop0 = mon_eop;
      send_preamble(1'b0);
      for (int i = 0; i < 30; i++) begin
         drive_nib(1'b1, 1'b0, frame[i][3:0]);
         drive_nib(1'b1, 1'b0, frame[i][7:4]);
      end
      @(negedge eth_rxclk);
      rstn = 1'b0;
      #1;
      check("midreset stat_good", stat_good, 0);
      check("midreset stat_bad",  stat_bad,  0);
      check("midreset rx_data",   rx_data,   0);
      check("midreset rx_valid",  rx_valid,  0);
      for (int i = 0; i < 4; i++) drive_nib(1'b1, 1'b0, 4'h5);
      drive_nib(1'b0, 1'b0, 4'h0);
      rstn = 1'b1;
      repeat (10) @(negedge eth_rxclk);
      check("midreset no eop", mon_eop - e_eop0, 0);

      pv = mon_valid; pr = mon_err;
      send_frame(1'b0, 1'b0, -1, 1'b0, 12);
      check("post-reset valid count", mon_valid - pv, CRC ? 60 : 64);
      check("post-reset eop err",     mon_err - pr, 0);
      check("post-reset stat_good",   stat_good, 1);
      check("post-reset stat_bad",    stat_bad,  0);

      // Saturation: 2^STAT_W + 2 empty (bad) frames
      build(0, 1'b0, -1);
      for (int i = 1; i <= 18; i++) begin
         send_frame(1'b0, 1'b0, -1, 1'b0, 4);
         if (i == 14) check("stat_bad after 14", stat_bad, 14);
         if (i == 15) check("stat_bad after 15", stat_bad, 15);
      end
      check("stat_bad saturated", stat_bad,  15);
      check("stat_good unchanged", stat_good, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
